cbus_arbiter_rr: RTL and testbench



---
 rtl/cbus_arbiter_rr_pkg.sv | 40 ++++
 rtl/cbus_arbiter_rr_if.sv | 13 +
 rtl/cbus_arbiter_rr_rr_picker.sv | 32 +++
 rtl/cbus_arbiter_rr.sv | 118 +++++++++++
 tb/tb_cbus_arbiter_rr.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbus_arbiter_rr_pkg.sv
// rtl/cbus_arbiter_rr_pkg.sv - shared CBus types and arbiter constants
package cbus_arbiter_rr_pkg;

   localparam int MAX_PORTS = 8;
   localparam int ARB_IDX_W = $clog2(MAX_PORTS);

   // arbitration policy encodings for RR_MODE
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef logic [ARB_IDX_W-1:0] arb_idx_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [7:0]  len;
      logic [1:0]  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   // next index modulo n; i is always below n so one compare suffices
   function automatic arb_idx_t arb_wrap_inc(input arb_idx_t i, input int n);
      return (int'(i) + 1 >= n) ? '0 : i + arb_idx_t'(1);
   endfunction

endpackage

// File: rtl/cbus_arbiter_rr_if.sv
// rtl/cbus_arbiter_rr_if.sv - requester and memory side CBus bundle
interface cbus_arbiter_rr_if #(parameter int NUM_PORTS = 2);
   import cbus_arbiter_rr_pkg::*;

   cbus_req_t  ireqs  [NUM_PORTS];
   cbus_resp_t iresps [NUM_PORTS];
   cbus_req_t  oreq;
   cbus_resp_t oresp;

   // master: requesters plus memory model; slave: the arbiter
   modport master (output ireqs, output oresp, input iresps, input oreq);
   modport slave  (input ireqs, input oresp, output iresps, output oreq);
endinterface

// File: rtl/cbus_arbiter_rr_rr_picker.sv
// rtl/cbus_arbiter_rr_rr_picker.sv - first set valid bit at or after a pointer
module cbus_arbiter_rr_rr_picker
   import cbus_arbiter_rr_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0] valid,
   input  arb_idx_t     ptr,
   output arb_idx_t     idx,
   output logic         any
);

   logic [N-1:0] rotated;
   int           sum;

   // rotate so bit 0 is the pointer slot, take the lowest set bit, map back modulo N
   always_comb begin
      rotated = N'({valid, valid} >> ptr);
      any     = |valid;
      sum     = int'(ptr);
      for (int i = N - 1; i >= 0; i--) begin
         if (rotated[i]) begin
            sum = int'(ptr) + i;
         end
      end
      if (sum >= N) begin
         sum = sum - N;
      end
      idx = arb_idx_t'(sum);
   end

endmodule

// File: rtl/cbus_arbiter_rr.sv
// rtl/cbus_arbiter_rr.sv - N-port CBus arbiter with burst hold and completion counters
module cbus_arbiter_rr
   import cbus_arbiter_rr_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int RR_MODE   = 1,
   parameter int CNT_W     = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   cbus_arbiter_rr_if.slave             bus,
   output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
   output logic                         busy,
   output logic [CNT_W-1:0]             done_cnt [NUM_PORTS]
);

   localparam int GW = $clog2(NUM_PORTS);

   arb_state_t           state;
   arb_state_t           state_nxt;
   arb_idx_t             idx;
   arb_idx_t             rr_ptr;
   arb_idx_t             pick_ptr;
   arb_idx_t             pick_idx;
   logic                 pick_any;
   logic                 done;
   logic [NUM_PORTS-1:0] req_valid;

   // gather request valids for the picker
   always_comb begin
      req_valid = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         req_valid[i] = bus.ireqs[i].valid;
      end
   end

   // fixed priority is round robin with the pointer pinned at port 0
   assign pick_ptr = (RR_MODE == ARB_RR) ? rr_ptr : '0;

   cbus_arbiter_rr_rr_picker #(.N(NUM_PORTS)) u_picker (
      .valid (req_valid),
      .ptr   (pick_ptr),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // completion is sampled from registered busy only, never feeding the same-cycle pick
   assign done = (state == ST_BUSY) && bus.oresp.ready && bus.oresp.last;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state: grant on any valid, release on the last ready beat
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: state_nxt = pick_any ? ST_BUSY : ST_IDLE;
         ST_BUSY: state_nxt = done ? ST_IDLE : ST_BUSY;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // outputs: route granted port to memory and memory response back to it
   always_comb begin
      busy     = (state == ST_BUSY);
      bus.oreq = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         bus.iresps[i] = '0;
      end
      if (busy) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == arb_idx_t'(i)) begin
               bus.oreq      = bus.ireqs[i];
               bus.iresps[i] = bus.oresp;
            end
         end
      end
   end

   assign grant_idx = idx[GW-1:0];

   // grant index and round-robin pointer, updated only at grant and completion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx    <= '0;
         rr_ptr <= '0;
      end else begin
         if (state == ST_IDLE && pick_any) begin
            idx <= pick_idx;
         end
         if (done && RR_MODE == ARB_RR) begin
            rr_ptr <= arb_wrap_inc(idx, NUM_PORTS);
         end
      end
   end

   // per-port saturating completion counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            done_cnt[i] <= '0;
         end
      end else if (done) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == arb_idx_t'(i) && done_cnt[i] != '1) begin
               done_cnt[i] <= done_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// tb/tb_cbus_arbiter_rr.sv - directed vector bench for cbus_arbiter_rr
module tb_cbus_arbiter_rr;
   import cbus_arbiter_rr_pkg::*;

   localparam logic [31:0] A0 = 32'h8000_0000;
   localparam logic [31:0] A1 = 32'h8000_0100;
   localparam logic [31:0] A2 = 32'h8000_0200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cbus_arbiter_rr_if #(.NUM_PORTS(2)) b2r ();
   cbus_arbiter_rr_if #(.NUM_PORTS(2)) b2f ();
   cbus_arbiter_rr_if #(.NUM_PORTS(3)) b3r ();

   logic [0:0]  g2r, g2f;
   logic [1:0]  g3r;
   logic        busy2r, busy2f, busy3r;
   logic [31:0] cnt2r [2];
   logic [2:0]  cnt2f [2];
   logic [7:0]  cnt3r [3];

   cbus_arbiter_rr #(.NUM_PORTS(2), .RR_MODE(1), .CNT_W(32)) u_rr2 (
      .clk(clk), .reset(rst), .bus(b2r), .grant_idx(g2r), .busy(busy2r), .done_cnt(cnt2r));
   cbus_arbiter_rr #(.NUM_PORTS(2), .RR_MODE(0), .CNT_W(3)) u_fx2 (
      .clk(clk), .reset(rst), .bus(b2f), .grant_idx(g2f), .busy(busy2f), .done_cnt(cnt2f));
   cbus_arbiter_rr #(.NUM_PORTS(3), .RR_MODE(1), .CNT_W(8)) u_rr3 (
      .clk(clk), .reset(rst), .bus(b3r), .grant_idx(g3r), .busy(busy3r), .done_cnt(cnt3r));

   typedef struct {
      logic [2:0]  v;
      logic        rdy;
      logic        lst;
      logic        ebusy;
      logic [2:0]  egnt;
      logic        eoval;
      logic [31:0] eaddr;
      logic [2:0]  eirdy;
   } vec_t;

   vec_t tbl [24];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input int exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic cbus_req_t mk_req(input logic v, input int p, input logic [7:0] len);
      cbus_req_t r;
      r          = '0;
      r.valid    = v;
      r.is_write = p[0];
      r.size     = 3'd2;
      r.addr     = 32'h8000_0000 + 32'(p) * 32'h100;
      r.strobe   = 4'hF;
      r.data     = 32'hD000_0000 + 32'(p);
      r.len      = len;
      r.burst    = 2'b01;
      return r;
   endfunction

   function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst);
      cbus_resp_t r;
      r.ready = rdy;
      r.last  = lst;
      r.data  = 32'h5A5A_0000;
      return r;
   endfunction

   task automatic drive2r(input logic [1:0] v, input logic rdy, input logic lst);
      for (int p = 0; p < 2; p++) b2r.ireqs[p] = mk_req(v[p], p, 8'd0);
      b2r.oresp = mk_resp(rdy, lst);
   endtask

   task automatic drive2f(input logic [1:0] v, input logic rdy, input logic lst);
      for (int p = 0; p < 2; p++) b2f.ireqs[p] = mk_req(v[p], p, 8'd0);
      b2f.oresp = mk_resp(rdy, lst);
   endtask

   task automatic drive3r(input logic [2:0] v, input logic rdy, input logic lst);
      for (int p = 0; p < 3; p++)
         b3r.ireqs[p] = mk_req(v[p], p, (p == 2) ? 8'd15 : (p == 1) ? 8'd7 : 8'd0);
      b3r.oresp = mk_resp(rdy, lst);
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      //            v       rdy   lst   busy  gnt   oval  addr   irdy
      tbl[0]  = '{3'b010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 3'b000};
      tbl[1]  = '{3'b010, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, A1,    3'b000};
      tbl[2]  = '{3'b010, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, A1,    3'b000};
      tbl[3]  = '{3'b010, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, A1,    3'b010};
      tbl[4]  = '{3'b000, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 32'h0, 3'b000};
      tbl[5]  = '{3'b011, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'h0, 3'b000};
      tbl[6]  = '{3'b011, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, A0,    3'b001};
      tbl[7]  = '{3'b011, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 3'b000};
      tbl[8]  = '{3'b011, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, A1,    3'b010};
      tbl[9]  = '{3'b011, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 32'h0, 3'b000};
      tbl[10] = '{3'b011, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, A0,    3'b001};
      tbl[11] = '{3'b011, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 3'b000};
      tbl[12] = '{3'b011, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, A1,    3'b010};
      tbl[13] = '{3'b000, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'h0, 3'b000};
      tbl[14] = '{3'b001, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'h0, 3'b000};
      tbl[15] = '{3'b001, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1, A0,    3'b001};
      tbl[16] = '{3'b000, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, A0,    3'b000};
      tbl[17] = '{3'b000, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, A0,    3'b001};
      tbl[18] = '{3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 3'b000};
      tbl[19] = '{3'b010, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 3'b000};
      tbl[20] = '{3'b010, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, A1,    3'b010};
      tbl[21] = '{3'b010, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 32'h0, 3'b000};
      tbl[22] = '{3'b010, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1, A1,    3'b010};
      tbl[23] = '{3'b000, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 32'h0, 3'b000};

      drive2r(2'b00, 1'b0, 1'b0);
      drive2f(2'b00, 1'b0, 1'b0);
      drive3r(3'b000, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);

      // reset state
      chk("rst_busy2r", 32'(busy2r), 0);
      chk("rst_oreq2r_zero", 32'(b2r.oreq == '0), 1);
      chk("rst_iresp3r_zero", 32'((b3r.iresps[0] == '0) && (b3r.iresps[1] == '0) && (b3r.iresps[2] == '0)), 1);
      chk("rst_cnt2r", cnt2r[0] | cnt2r[1], 0);
      chk("rst_busy3r", 32'(busy3r), 0);
      rst = 1'b0;
      step;

      // table: single request, RR contention, ready without last, dropped valid, single repeater
      for (int i = 0; i < 24; i++) begin
         drive2r(tbl[i].v[1:0], tbl[i].rdy, tbl[i].lst);
         #1;
         chk($sformatf("tbl%0d_busy", i), 32'(busy2r), int'(tbl[i].ebusy));
         chk($sformatf("tbl%0d_gnt", i), 32'(g2r), int'(tbl[i].egnt));
         chk($sformatf("tbl%0d_oval", i), 32'(b2r.oreq.valid), int'(tbl[i].eoval));
         chk($sformatf("tbl%0d_addr", i), b2r.oreq.addr, int'(tbl[i].eaddr));
         chk($sformatf("tbl%0d_irdy", i), 32'({b2r.iresps[1].ready, b2r.iresps[0].ready}),
             int'(tbl[i].eirdy[1:0]));
         step;
      end
      chk("rr2_cnt0", cnt2r[0], 3);
      chk("rr2_cnt1", cnt2r[1], 5);

      // fixed priority: port 0 wins every time, counter saturates at 7
      drive2f(2'b11, 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk($sformatf("fx_idle%0d", k), 32'(busy2f), 0);
         chk($sformatf("fx_cnt0_%0d", k), 32'(cnt2f[0]), k);
         step;
         #1;
         chk($sformatf("fx_busy%0d", k), 32'(busy2f), 1);
         chk($sformatf("fx_gnt%0d", k), 32'(g2f), 0);
         chk($sformatf("fx_p1rdy%0d", k), 32'(b2f.iresps[1].ready), 0);
         step;
      end
      drive2f(2'b00, 1'b0, 1'b0);
      #1;
      chk("fx_cnt0_sat", 32'(cnt2f[0]), 7);
      chk("fx_cnt1", 32'(cnt2f[1]), 0);
      step;

      // burst hold: port 2 sixteen beats, port 0 waits from beat 4
      drive3r(3'b100, 1'b0, 1'b0);
      #1;
      chk("bh_idle", 32'(busy3r), 0);
      step;
      for (int b = 1; b <= 16; b++) begin
         drive3r((b >= 4) ? 3'b101 : 3'b100, 1'b1, (b == 16));
         #1;
         chk($sformatf("bh_busy%0d", b), 32'(busy3r), 1);
         chk($sformatf("bh_gnt%0d", b), 32'(g3r), 2);
         chk($sformatf("bh_len%0d", b), 32'(b3r.oreq.len), 15);
         chk($sformatf("bh_p0rdy%0d", b), 32'(b3r.iresps[0].ready), 0);
         chk($sformatf("bh_p2rdy%0d", b), 32'(b3r.iresps[2].ready), 1);
         step;
      end
      drive3r(3'b001, 1'b0, 1'b0);
      #1;
      chk("bh_bubble", 32'(busy3r), 0);
      step;
      drive3r(3'b001, 1'b1, 1'b1);
      #1;
      chk("bh_p0_busy", 32'(busy3r), 1);
      chk("bh_p0_gnt", 32'(g3r), 0);
      chk("bh_p0_addr", b3r.oreq.addr, A0);
      step;

      // port 1 transaction moves the pointer to 2
      drive3r(3'b010, 1'b0, 1'b0);
      #1;
      step;
      drive3r(3'b010, 1'b1, 1'b1);
      #1;
      chk("wr_p1_gnt", 32'(g3r), 1);
      step;

      // wrap: ports 0 and 2 with pointer 2 -> 2, then 0, then 2 again (pointer 1)
      drive3r(3'b101, 1'b1, 1'b1);
      #1;
      chk("wr_idle0", 32'(busy3r), 0);
      step;
      #1;
      chk("wr_gnt_a", 32'(g3r), 2);
      chk("wr_addr_a", b3r.oreq.addr, A2);
      step;
      #1;
      chk("wr_idle1", 32'(busy3r), 0);
      step;
      #1;
      chk("wr_gnt_b", 32'(g3r), 0);
      step;
      #1;
      chk("wr_idle2", 32'(busy3r), 0);
      step;
      #1;
      chk("wr_gnt_c", 32'(g3r), 2);
      step;
      drive3r(3'b000, 1'b0, 1'b0);
      #1;
      chk("rr3_cnt0", 32'(cnt3r[0]), 2);
      chk("rr3_cnt1", 32'(cnt3r[1]), 1);
      chk("rr3_cnt2", 32'(cnt3r[2]), 3);
      step;

      // asynchronous reset during beat 5 of an 8-beat burst
      drive3r(3'b010, 1'b0, 1'b0);
      #1;
      step;
      for (int b = 1; b <= 4; b++) begin
         drive3r(3'b010, 1'b1, 1'b0);
         #1;
         chk($sformatf("ar_gnt%0d", b), 32'(g3r), 1);
         step;
      end
      drive3r(3'b010, 1'b1, 1'b0);
      #1;
      chk("ar_beat5_busy", 32'(busy3r), 1);
      rst = 1'b1;
      #1;
      chk("ar_oval", 32'(b3r.oreq.valid), 0);
      chk("ar_busy", 32'(busy3r), 0);
      chk("ar_cnt3r", 32'(cnt3r[0] | cnt3r[1] | cnt3r[2]), 0);
      chk("ar_cnt2r", cnt2r[0] | cnt2r[1], 0);
      chk("ar_cnt2f", 32'(cnt2f[0]), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ar_post_idle", 32'(busy3r), 0);
      step;
      #1;
      chk("ar_resume_busy", 32'(busy3r), 1);
      chk("ar_resume_gnt", 32'(g3r), 1);
      chk("ar_resume_oval", 32'(b3r.oreq.valid), 1);
      drive3r(3'b000, 1'b0, 1'b0);
      step;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
